// File: rtl/spi_sclk_gen.sv
// SPI master SCLK divider and launch/sample strobe generator; frames one 8-bit transfer (16 edges) per SS assertion.
// Optional debug port edge_cnt_o is present when SPI_SCLK_GEN_EDGE_CNT_EN is defined.
module spi_sclk_gen (
    input  logic        PCLK,
    input  logic        PRESET_n,
    input  logic        spe_i,
    input  logic        ss_i,
    input  logic        cpol_i,
    input  logic        cpha_i,
    input  logic [2:0]  sppr_i,
    input  logic [2:0]  spr_i,
    output logic        sclk_o,
    output logic        mosi_send_sclk_o,
    output logic        miso_receive_sclk_o,
    output logic        mosi_send_sclk0_o,
    output logic        miso_receive_sclk0_o,
    output logic [11:0] baud_div_o,
    output logic        tip_o,
    output logic        done_o
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
    ,
    output logic [4:0]  edge_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_EDGE = 5'd16;

    state_t      state, state_next;
    logic [10:0] half_len;
    logic [9:0]  half_last_in;
    logic [9:0]  half_cnt;
    logic [9:0]  half_last;
    logic [4:0]  edge_cnt;
    logic [4:0]  edge_num;
    logic        armed;
    logic        pha_q;
    logic        alt_pair_q;
    logic        alt_pair;
    logic        start;
    logic        abort;
    logic        edge_hit;
    logic        launch;
    logic        sample;

    assign baud_div_o   = ({9'd0, sppr_i} + 12'd1) << ({1'b0, spr_i} + 4'd1);
    assign half_len     = ({8'd0, sppr_i} + 11'd1) << spr_i;
    assign half_last_in = 10'(half_len - 11'd1);

    // armed requires SS to be seen high before a new falling edge can start a transfer
    assign start    = spe_i & ~ss_i & armed;
    assign abort    = ~spe_i | ss_i;
    assign edge_hit = (half_cnt == half_last);
    assign edge_num = edge_cnt + 5'd1;
    assign alt_pair = (state == IDLE) ? (cpol_i ^ cpha_i) : alt_pair_q;
    assign tip_o    = (state == RUN);

`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
    assign edge_cnt_o = edge_cnt;
`endif

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    launch     = ~cpha_i;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (edge_cnt == LAST_EDGE) begin
                    state_next = DONE;
                end else if (edge_hit) begin
                    // odd edges are the leading edge of each bit, even edges the trailing one
                    if (edge_num[0]) begin
                        launch = pha_q;
                        sample = ~pha_q;
                    end else begin
                        launch = ~pha_q & (edge_num != LAST_EDGE);
                        sample = pha_q;
                    end
                end
            end
            DONE: begin
                if (abort) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            half_cnt   <= '0;
            half_last  <= '0;
            edge_cnt   <= '0;
            sclk_o     <= 1'b0;
            armed      <= 1'b0;
            pha_q      <= 1'b0;
            alt_pair_q <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= (state == RUN) && (state_next == DONE);

            if (ss_i)
                armed <= 1'b1;
            else if (state == IDLE && start)
                armed <= 1'b0;

            if (state == RUN && state_next == RUN) begin
                if (edge_hit) begin
                    sclk_o   <= ~sclk_o;
                    half_cnt <= '0;
                    edge_cnt <= edge_num;
                end else begin
                    half_cnt <= half_cnt + 10'd1;
                end
            end else begin
                sclk_o   <= cpol_i;
                half_cnt <= '0;
                edge_cnt <= (state_next == DONE) ? LAST_EDGE : 5'd0;
            end

            // divisor and phase are frozen for the whole transfer
            if (state == IDLE && start) begin
                half_last  <= half_last_in;
                pha_q      <= cpha_i;
                alt_pair_q <= cpol_i ^ cpha_i;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            mosi_send_sclk_o     <= 1'b0;
            miso_receive_sclk_o  <= 1'b0;
            mosi_send_sclk0_o    <= 1'b0;
            miso_receive_sclk0_o <= 1'b0;
        end else begin
            mosi_send_sclk_o     <= launch & ~alt_pair;
            miso_receive_sclk_o  <= sample & ~alt_pair;
            mosi_send_sclk0_o    <= launch &  alt_pair;
            miso_receive_sclk0_o <= sample &  alt_pair;
        end
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: per-cycle comparison against a timeline model plus directed transfer checks.
module tb_spi_sclk_gen;

    logic        PCLK = 1'b0;
    logic        PRESET_n = 1'b1;
    logic        spe_i = 1'b0;
    logic        ss_i = 1'b1;
    logic        cpol_i = 1'b0;
    logic        cpha_i = 1'b0;
    logic [2:0]  sppr_i = 3'd0;
    logic [2:0]  spr_i = 3'd0;
    logic        sclk_o, mosi_send_sclk_o, miso_receive_sclk_o;
    logic        mosi_send_sclk0_o, miso_receive_sclk0_o;
    logic [11:0] baud_div_o;
    logic        tip_o, done_o;
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
    logic [4:0]  edge_cnt_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    spi_sclk_gen dut (
        .PCLK                 (PCLK),
        .PRESET_n             (PRESET_n),
        .spe_i                (spe_i),
        .ss_i                 (ss_i),
        .cpol_i               (cpol_i),
        .cpha_i               (cpha_i),
        .sppr_i               (sppr_i),
        .spr_i                (spr_i),
        .sclk_o               (sclk_o),
        .mosi_send_sclk_o     (mosi_send_sclk_o),
        .miso_receive_sclk_o  (miso_receive_sclk_o),
        .mosi_send_sclk0_o    (mosi_send_sclk0_o),
        .miso_receive_sclk0_o (miso_receive_sclk0_o),
        .baud_div_o           (baud_div_o),
        .tip_o                (tip_o),
        .done_o               (done_o)
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
        ,
        .edge_cnt_o           (edge_cnt_o)
`endif
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Timeline model: phase (0 idle, 1 run, 2 done) and cycles elapsed since RUN entry
    bit m_rst = 1'b1;
    int m_st = 0;
    int m_t = 0;
    int m_h = 1;
    bit m_armed = 1'b0;
    bit m_done = 1'b0;
    bit m_lvl = 1'b0;
    bit m_cpol = 1'b0;
    bit m_cpha = 1'b0;
    bit m_go;

    initial forever begin
        @(posedge PCLK or negedge PRESET_n);
        if (!PRESET_n) begin
            m_rst = 1'b1; m_st = 0; m_armed = 1'b0; m_done = 1'b0; m_lvl = 1'b0;
        end else begin
            m_rst  = 1'b0;
            m_done = 1'b0;
            m_go   = 1'b0;
            case (m_st)
                0: if (spe_i && !ss_i && m_armed) begin
                       m_go = 1'b1; m_st = 1; m_t = 0;
                       m_h = (int'(sppr_i) + 1) << spr_i;
                       m_cpol = cpol_i; m_cpha = cpha_i;
                   end
                1: if (!spe_i || ss_i) m_st = 0;
                   else if (m_t == 16 * m_h) begin m_st = 2; m_done = 1'b1; end
                   else m_t++;
                default: if (!spe_i || ss_i) m_st = 0;
            endcase
            if (ss_i) m_armed = 1'b1;
            else if (m_go) m_armed = 1'b0;
            m_lvl = cpol_i;
        end
    end

    // Compare process plus transfer statistics
    int cyc = 0, tip_start = -1, first_launch = -1, done_rel = -1, n_done = 0;
    int n_ms = 0, n_mr = 0, n_ms0 = 0, n_mr0 = 0;
    bit tip_q = 1'b0;
    int k, e_ec;
    bit e_sclk, e_launch, e_sample, e_pair;

    task automatic clr();
        tip_start = -1; first_launch = -1; done_rel = -1; n_done = 0;
        n_ms = 0; n_mr = 0; n_ms0 = 0; n_mr0 = 0;
    endtask

    initial forever begin
        @(negedge PCLK);
        cyc++;
        e_launch = 1'b0; e_sample = 1'b0; e_ec = 0;
        e_pair = m_cpol ^ m_cpha;
        if (m_rst) begin
            e_sclk = 1'b0;
        end else if (m_st == 1) begin
            k = m_t / m_h;
            e_sclk = m_cpol ^ (k % 2 == 1);
            e_ec = k;
            if (m_t == 0) e_launch = !m_cpha;
            else if (m_t % m_h == 0) begin
                if (k % 2 == 1) begin e_launch = m_cpha; e_sample = !m_cpha; end
                else begin e_sample = m_cpha; e_launch = !m_cpha && k < 16; end
            end
        end else begin
            e_sclk = m_lvl;
            e_ec = (m_st == 2) ? 16 : 0;
        end
        check("sclk", sclk_o, e_sclk);
        check("strobes[ms,mr,ms0,mr0]",
              {mosi_send_sclk_o, miso_receive_sclk_o, mosi_send_sclk0_o, miso_receive_sclk0_o},
              {e_launch & ~e_pair, e_sample & ~e_pair, e_launch & e_pair, e_sample & e_pair});
        check("tip", tip_o, (m_st == 1) ? 1 : 0);
        check("done", done_o, m_done);
        check("baud_div", baud_div_o, (int'(sppr_i) + 1) * (1 << (int'(spr_i) + 1)));
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
        check("edge_cnt", edge_cnt_o, e_ec);
`endif
        if (PRESET_n) begin
            if (tip_o && !tip_q) tip_start = cyc;
            if ((mosi_send_sclk_o || mosi_send_sclk0_o) && first_launch < 0) first_launch = cyc;
            n_ms  += int'(mosi_send_sclk_o);
            n_mr  += int'(miso_receive_sclk_o);
            n_ms0 += int'(mosi_send_sclk0_o);
            n_mr0 += int'(miso_receive_sclk0_o);
            if (done_o) begin n_done++; done_rel = cyc - tip_start; end
        end
        tip_q = tip_o;
    end

    task automatic xfer(input logic [2:0] pp, input logic [2:0] rr, input bit pol, input bit pha,
                        input int h, input int l_ms, input int l_mr, input int l_ms0, input int l_mr0,
                        input int done_at, input string tag);
        sppr_i = pp; spr_i = rr; cpol_i = pol; cpha_i = pha; spe_i = 1'b1; ss_i = 1'b1;
        tick(2);
        clr();
        ss_i = 1'b0;
        tick(16 * h + 4);
        check({tag, " mosi_send"}, n_ms, l_ms);
        check({tag, " miso_receive"}, n_mr, l_mr);
        check({tag, " mosi_send0"}, n_ms0, l_ms0);
        check({tag, " miso_receive0"}, n_mr0, l_mr0);
        check({tag, " done count"}, n_done, 1);
        check({tag, " done cycle"}, done_rel, done_at);
        check({tag, " first launch offset"}, first_launch - tip_start, pha ? h : 0);
        ss_i = 1'b1;
        tick(2);
    endtask

    initial begin
        #1 PRESET_n = 1'b0;
        #1;
        check("reset sclk", sclk_o, 0);
        check("reset strobes", {mosi_send_sclk_o, miso_receive_sclk_o, mosi_send_sclk0_o, miso_receive_sclk0_o}, 0);
        check("reset tip", tip_o, 0);
        check("reset done", done_o, 0);
        tick(2);
        PRESET_n = 1'b1;
        cpol_i = 1'b1;
        tick(1);
        check("idle follows cpol=1", sclk_o, 1);
        cpol_i = 1'b0;
        tick(1);
        check("idle follows cpol=0", sclk_o, 0);
        check("baud H=1", baud_div_o, 2);

        xfer(3'd0, 3'd0, 1'b0, 1'b0, 1, 8, 8, 0, 0, 17, "mode0 H1");
        sppr_i = 3'd2; spr_i = 3'd1;
        #1 check("baud 2/1", baud_div_o, 12);
        xfer(3'd2, 3'd1, 1'b1, 1'b1, 6, 8, 8, 0, 0, 97, "mode3 H6");
        xfer(3'd1, 3'd0, 1'b0, 1'b1, 2, 0, 0, 8, 8, 33, "mode1 H2");
        xfer(3'd1, 3'd0, 1'b1, 1'b0, 2, 0, 0, 8, 8, 33, "mode2 H2");
        sppr_i = 3'd7; spr_i = 3'd7;
        #1 check("baud max", baud_div_o, 2048);

        // abort after edge 5 at H=4, then restart
        sppr_i = 3'd3; spr_i = 3'd0; cpol_i = 1'b0; cpha_i = 1'b0; ss_i = 1'b1;
        tick(2);
        clr();
        ss_i = 1'b0;
        tick(23);
        check("abort sclk high before", sclk_o, 1);
        ss_i = 1'b1;
        tick(1);
        check("abort tip", tip_o, 0);
        check("abort sclk", sclk_o, 0);
        tick(3);
        check("abort done count", n_done, 0);
        check("abort launches", n_ms, 3);
        check("abort samples", n_mr, 3);
        xfer(3'd3, 3'd0, 1'b0, 1'b0, 4, 8, 8, 0, 0, 65, "restart H4");

        // divisor changed mid-transfer
        sppr_i = 3'd1; spr_i = 3'd0; ss_i = 1'b1;
        tick(2);
        clr();
        ss_i = 1'b0;
        tick(11);
        sppr_i = 3'd3;
        tick(25);
        check("midchange done cycle", done_rel, 33);
        check("midchange launches", n_ms, 8);
        check("midchange samples", n_mr, 8);
        ss_i = 1'b1;
        tick(2);
        xfer(3'd3, 3'd0, 1'b0, 1'b0, 4, 8, 8, 0, 0, 65, "new H4");

        // asynchronous reset mid-transfer
        sppr_i = 3'd1; spr_i = 3'd0; ss_i = 1'b1;
        tick(2);
        clr();
        ss_i = 1'b0;
        tick(8);
        check("pre-reset sclk", sclk_o, 1);
        check("pre-reset tip", tip_o, 1);
        #2 PRESET_n = 1'b0;
        #1;
        check("midrun reset sclk", sclk_o, 0);
        check("midrun reset tip", tip_o, 0);
        check("midrun reset done", done_o, 0);
        check("midrun reset strobes", {mosi_send_sclk_o, miso_receive_sclk_o, mosi_send_sclk0_o, miso_receive_sclk0_o}, 0);
        tick(1);
        PRESET_n = 1'b1;
        clr();
        tick(10);
        check("no restart tip", tip_o, 0);
        check("no restart tip_start", tip_start, -1);
        check("no restart done", n_done, 0);
        xfer(3'd1, 3'd0, 1'b0, 1'b0, 2, 8, 8, 0, 0, 33, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

SPI master serial-clock and bit-strobe generator. It divides PCLK by the programmed baud divisor and drives SCLK with the selected CPOL/CPHA. It issues the single-cycle launch/sample strobes that the SPI shifter consumes to drive MOSI and capture MISO. It sits between the APB control registers / slave-select control and the shifter, and frames exactly one 8-bit transfer (16 SCLK edges) per slave-select assertion.

## Interface
Parameters:
- none (divisor width fixed by SPPR/SPR encoding)

Ports:
- PCLK  in  1  system clock
- PRESET_n  in  1  reset, asynchronous, active-low
- spe_i  in  1  SPI enable; low forces IDLE
- ss_i  in  1  slave select, active-low; falling into low starts a transfer
- cpol_i  in  1  SCLK idle level
- cpha_i  in  1  clock phase (0: sample leading edge, 1: sample trailing edge)
- sppr_i  in  3  baud pre-selection
- spr_i  in  3  baud selection
- sclk_o  out  1  serial clock to pad
- mosi_send_sclk_o  out  1  launch strobe, modes 0/3 (falling edge)
- miso_receive_sclk_o  out  1  sample strobe, modes 0/3 (rising edge)
- mosi_send_sclk0_o  out  1  launch strobe, modes 1/2 (rising edge)
- miso_receive_sclk0_o  out  1  sample strobe, modes 1/2 (falling edge)
- baud_div_o  out  12  current divisor (SPPR+1)*2^(SPR+1), combinational from inputs
- tip_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse after the 16th SCLK edge

## Operation
- Half period H = (sppr_i+1) << spr_i PCLK cycles; range 1..1024. Half counter 10 bits, counts 0..H-1. H is latched on the IDLE->RUN transition; register changes during RUN are ignored.
- States:
  - IDLE: sclk_o = cpol_i; counters cleared; tip_o = 0. Goes to RUN when spe_i=1 and ss_i=0.
  - RUN: tip_o = 1. When the half counter reaches H-1, sclk_o toggles, the counter returns to 0 and the 5-bit edge counter increments. After edge 16, goes to DONE.
  - DONE: done_o pulses for 1 cycle on entry; sclk_o at idle level; tip_o = 0. Stays in DONE while ss_i=0, goes to IDLE when ss_i=1.
- Edge strobes are asserted in the same PCLK cycle that sclk_o is registered to toggle:
  - Falling-edge cycle: mosi_send_sclk_o and miso_receive_sclk0_o.
  - Rising-edge cycle: miso_receive_sclk_o and mosi_send_sclk0_o.
  - Only the pair matching cpol_i^cpha_i is qualified: 0 -> non-0 pair, 1 -> "0" pair. The other pair stays 0.
- CPHA=0:
  - Extra launch strobe in the first RUN cycle.
  - Launch strobes on even edges 2..14; the launch on edge 16 is suppressed.
  - Samples on odd edges 1..15.
- CPHA=1: launch on odd edges 1..15, sample on even edges 2..16.
- Each transfer produces exactly 8 launch and 8 sample strobes.
- Abort: ss_i=1 or spe_i=0 during RUN -> IDLE next cycle; sclk_o returns to cpol_i; no done_o; no further strobes.

## Timing
- Reset values: sclk_o=0, all strobes=0, tip_o=0, done_o=0, state IDLE. sclk_o follows cpol_i from the first cycle after reset release.
- First SCLK edge occurs H cycles after the RUN entry cycle. Edge k occurs at k*H. done_o is asserted at cycle 16*H+1 relative to RUN entry.
- Strobes are registered: 1 PCLK wide, coincident with the sclk_o transition.
- With H=1, sclk_o toggles every cycle and a strobe is present in every RUN cycle.
- ss_i falling while in DONE is ignored; ss_i must return high first.
- Asynchronous reset mid-RUN clears everything immediately, with no done_o.

## Configuration
- SPI_SCLK_GEN_EDGE_CNT_EN:
  - Defined: adds output port edge_cnt_o[4:0] carrying the live edge counter (0 in IDLE, 16 in DONE) for debug/bench observation.
  - Undefined: the port is absent and behaviour is otherwise identical.

## Test plan
- sppr=0, spr=0, mode 0, ss_i low -> H=1, 16 toggles on consecutive cycles, done_o at cycle 17, 8 mosi_send_sclk_o pulses with the first at RUN entry.
- sppr=2, spr=1 (baud_div_o=12, H=6), mode 3 -> sclk_o idle 1, edges every 6 cycles, 8 falling-edge launches and 8 rising-edge samples, done_o at cycle 97.
- Mode 1 and mode 2 at H=2 -> only the sclk0 strobes toggle, the non-0 pair stays 0, and the sample count equals 8.
- ss_i raised after edge 5 at H=4 -> IDLE next cycle, sclk_o=cpol_i, no done_o; a restart re-counts from edge 1.
- sppr/spr changed mid-RUN -> edge spacing unchanged until the next transfer, which uses the new H.
- PRESET_n pulsed low mid-RUN -> all outputs zero immediately; ss_i held low after release does not restart until it is raised and lowered again.
